// File: rtl/dec24_seq.sv
// dec24_seq: registered 2-to-4 one-hot decoder with a valid/ready handshake
// on both sides, a self-stepping one-hot "scan" sweep mode and a saturating
// count of codes accepted in direct mode.
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   en         block enable; gates code acceptance and scan operation
//   scan       scan-mode request (1 = self-stepping one-hot sweep)
//   in_valid   A/B code valid
//   in_ready   block can accept a code this cycle
//   A, B       code MSB / LSB
//   out_valid  a..d carry a valid one-hot word
//   out_ready  consumer accepts the current word (ignored while scanning)
//   a, b, c, d one-hot decode: a={A,B}=00, b=01, c=10, d=11
//   count      number of codes accepted in direct mode, saturating
//
// Parameters
//   SCAN_DIV   cycles each one-hot value is held in scan mode (1..255)
//   CNT_W      width of the accepted-code counter

module dec24_seq #(
  parameter int SCAN_DIV = 10,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             scan,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             A,
  input  logic             B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic [CNT_W-1:0] count
);

  // IDLE has nothing to show, HOLD presents a decoded code until the
  // consumer takes it, SCAN sweeps the one-hot value on its own.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_word;
  logic [3:0]       w_nextWord;
  logic             r_valid;
  logic             w_nextValid;
  logic [1:0]       r_step;
  logic [1:0]       w_nextStep;
  logic [7:0]       r_div;
  logic [7:0]       w_nextDiv;
  logic [CNT_W-1:0] r_count;

  logic             w_inReady;
  logic             w_accept;
  logic [1:0]       w_code;
  logic [3:0]       w_codeWord;
  logic [1:0]       w_stepInc;
  logic [3:0]       w_stepIncWord;
  logic             w_countFull;

  // The input side is open only when no sweep is requested and either
  // nothing is pending or the pending word leaves this very cycle, which
  // gives back-to-back transfers without a bubble. Reset closes it too.
  always_comb begin
    w_inReady = rst_n & en & ~scan &
                ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready));
    w_accept  = in_valid & w_inReady;
  end

  // Word bit 0 drives a, so shifting a single one left by the code (or the
  // scan step) yields the one-hot pattern directly.
  always_comb begin
    w_code        = {A, B};
    w_codeWord    = 4'b0001 << w_code;
    w_stepInc     = r_step + 2'd1;
    w_stepIncWord = 4'b0001 << w_stepInc;
    w_countFull   = (r_count == {CNT_W{1'b1}});
  end

  // Next-state and next-output logic. Outputs are registered so there is
  // no combinational path from A/B to a..d; every transition therefore
  // computes the word that should be visible in the following cycle.
  // Leaving HOLD or SCAN always clears the word so a..d read 0000 whenever
  // out_valid is low.
  always_comb begin
    w_nextState = r_state;
    w_nextWord  = r_word;
    w_nextValid = r_valid;
    w_nextStep  = r_step;
    w_nextDiv   = r_div;

    case (r_state)
      ST_IDLE: begin
        if (en & scan) begin
          w_nextState = ST_SCAN;
          w_nextWord  = 4'b0001;
          w_nextValid = 1'b1;
          w_nextStep  = 2'd0;
          w_nextDiv   = 8'd0;
        end else if (w_accept) begin
          w_nextState = ST_HOLD;
          w_nextWord  = w_codeWord;
          w_nextValid = 1'b1;
        end
      end

      ST_HOLD: begin
        // A scan request only closes in_ready here; the pending word must
        // drain through IDLE before the sweep can start.
        if (out_ready) begin
          if (w_accept) begin
            w_nextState = ST_HOLD;
            w_nextWord  = w_codeWord;
            w_nextValid = 1'b1;
          end else begin
            w_nextState = ST_IDLE;
            w_nextWord  = 4'b0000;
            w_nextValid = 1'b0;
          end
        end
      end

      ST_SCAN: begin
        if (~scan | ~en) begin
          w_nextState = ST_IDLE;
          w_nextWord  = 4'b0000;
          w_nextValid = 1'b0;
          w_nextStep  = 2'd0;
          w_nextDiv   = 8'd0;
        end else if (r_div == DIV_LAST) begin
          // The divider runs 0..SCAN_DIV-1, so each step lasts exactly
          // SCAN_DIV cycles; the 2-bit step wraps 3 -> 0 by itself.
          w_nextDiv   = 8'd0;
          w_nextStep  = w_stepInc;
          w_nextWord  = w_stepIncWord;
        end else begin
          w_nextDiv   = r_div + 8'd1;
        end
      end

      default: begin
        w_nextState = ST_IDLE;
        w_nextWord  = 4'b0000;
        w_nextValid = 1'b0;
        w_nextStep  = 2'd0;
        w_nextDiv   = 8'd0;
      end
    endcase
  end

  // State and output registers. Reset discards any pending word or sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_word  <= 4'b0000;
      r_valid <= 1'b0;
      r_step  <= 2'd0;
      r_div   <= 8'd0;
    end else begin
      r_state <= w_nextState;
      r_word  <= w_nextWord;
      r_valid <= w_nextValid;
      r_step  <= w_nextStep;
      r_div   <= w_nextDiv;
    end
  end

  // Accepted-code counter: only direct-mode acceptances count, and it
  // sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_accept && !w_countFull) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready  = w_inReady;
    out_valid = r_valid;
    a         = r_word[0];
    b         = r_word[1];
    c         = r_word[2];
    d         = r_word[3];
    count     = r_count;
  end

endmodule

// File: tb/tb_dec24_seq.sv
// tb_dec24_seq: directed, table-driven bench for dec24_seq. A second
// instance with CNT_W=2 shares all inputs so counter saturation can be
// observed alongside the main instance (SCAN_DIV=3, CNT_W=8).

module tb_dec24_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       scan = 1'b0;
  logic       in_valid = 1'b0;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready;
  logic       out_valid;
  logic       a, b, c, d;
  logic [7:0] count;

  logic       in_ready2;
  logic       out_valid2;
  logic       a2, b2, c2, d2;
  logic [1:0] count2;

  int nTests = 0;
  int nFail  = 0;

  dec24_seq #(.SCAN_DIV(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .d(d), .count(count)
  );

  dec24_seq #(.SCAN_DIV(10), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan),
    .in_valid(in_valid), .in_ready(in_ready2), .A(A), .B(B),
    .out_valid(out_valid2), .out_ready(out_ready),
    .a(a2), .b(b2), .c(c2), .d(d2), .count(count2)
  );

  always #5 clk = ~clk;

  // One vector: inputs for a cycle, in_ready expected before the edge, and
  // registered outputs expected after it. Words are written {a,b,c,d}.
  typedef struct {
    logic       rstN, enV, scanV, inValid, codeA, codeB, outReady;
    logic       expReady;
    logic       expValid;
    logic [3:0] expWord;
    int         expCount;
    int         expCount2;
  } vec_t;

  vec_t vecs[18];

  // Inputs change on the falling edge, well away from the active edge.
  task automatic applyStimulus(input logic rN, input logic e, input logic s,
                               input logic iv, input logic ca, input logic cb,
                               input logic ordy);
    @(negedge clk);
    rst_n     = rN;
    en        = e;
    scan      = s;
    in_valid  = iv;
    A         = ca;
    B         = cb;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    logic [3:0] expWord;

    //          rst en sc iv A  B  ord | rdy | ov word     cnt c2
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 4'b0000, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 0, 0, 1,   0,   0, 4'b0000, 0, 0};
    // back-to-back stream 00,01,10,11
    vecs[2]  = '{1, 1, 0, 1, 0, 0, 1,   1,   1, 4'b1000, 1, 1};
    vecs[3]  = '{1, 1, 0, 1, 0, 1, 1,   1,   1, 4'b0100, 2, 2};
    vecs[4]  = '{1, 1, 0, 1, 1, 0, 1,   1,   1, 4'b0010, 3, 3};
    vecs[5]  = '{1, 1, 0, 1, 1, 1, 1,   1,   1, 4'b0001, 4, 3};
    vecs[6]  = '{1, 1, 0, 0, 0, 0, 1,   1,   0, 4'b0000, 4, 3};
    // code 10 held while consumer stalls, then drained
    vecs[7]  = '{1, 1, 0, 1, 1, 0, 0,   1,   1, 4'b0010, 5, 3};
    vecs[8]  = '{1, 1, 0, 1, 0, 1, 0,   0,   1, 4'b0010, 5, 3};
    vecs[9]  = '{1, 1, 0, 0, 0, 0, 1,   1,   0, 4'b0000, 5, 3};
    // en dropped with a word pending: retained, then consumable
    vecs[10] = '{1, 1, 0, 1, 1, 1, 0,   1,   1, 4'b0001, 6, 3};
    vecs[11] = '{1, 0, 0, 1, 0, 0, 0,   0,   1, 4'b0001, 6, 3};
    vecs[12] = '{1, 0, 0, 1, 0, 0, 1,   0,   0, 4'b0000, 6, 3};
    vecs[13] = '{1, 0, 0, 1, 0, 0, 1,   0,   0, 4'b0000, 6, 3};
    // scan requested while a word is pending
    vecs[14] = '{1, 1, 0, 1, 0, 1, 0,   1,   1, 4'b0100, 7, 3};
    vecs[15] = '{1, 1, 1, 1, 1, 0, 0,   0,   1, 4'b0100, 7, 3};
    vecs[16] = '{1, 1, 1, 0, 0, 0, 0,   0,   1, 4'b0100, 7, 3};
    vecs[17] = '{1, 1, 1, 1, 0, 0, 1,   0,   0, 4'b0000, 7, 3};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].enV, vecs[i].scanV, vecs[i].inValid,
                    vecs[i].codeA, vecs[i].codeB, vecs[i].outReady);
      #1;
      checkOutput($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("v%0d word", i), 32'({a, b, c, d}), 32'(vecs[i].expWord));
      checkOutput($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].expCount));
      checkOutput($sformatf("v%0d count2", i), 32'(count2), 32'(vecs[i].expCount2));
    end

    // Sweep from IDLE: each one-hot value for 3 cycles, then a again.
    // out_ready toggles and in_valid stays high to show both are ignored.
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1, 1, 1, 1, k[1], k[0], k[0]);
      #1;
      checkOutput($sformatf("scan%0d in_ready", k), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      expWord = 4'b1000 >> ((k / 3) % 4);
      checkOutput($sformatf("scan%0d out_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("scan%0d word", k), 32'({a, b, c, d}), 32'(expWord));
      checkOutput($sformatf("scan%0d count", k), 32'(count), 32'd7);
    end

    // Dropping scan leaves SCAN on the next edge.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("scanoff in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("scanoff out_valid", 32'(out_valid), 32'd0);
    checkOutput("scanoff word", 32'({a, b, c, d}), 32'd0);

    // Dropping en also leaves SCAN; re-entry restarts at a.
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("reentry word", 32'({a, b, c, d}), 32'b1000);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("enoff out_valid", 32'(out_valid), 32'd0);
    checkOutput("enoff word", 32'({a, b, c, d}), 32'd0);

    // Reset pulse while the sweep is on step 2 (c).
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      @(posedge clk);
    end
    #1;
    checkOutput("prereset word", 32'({a, b, c, d}), 32'b0010);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset word", 32'({a, b, c, d}), 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset count2", 32'(count2), 32'd0);

    // First cycle after release is IDLE: a code is accepted at once.
    applyStimulus(1, 1, 0, 1, 1, 1, 0);
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("release out_valid", 32'(out_valid), 32'd1);
    checkOutput("release word", 32'({a, b, c, d}), 32'b0001);
    checkOutput("release count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dec24_seq.md
DEC24_SEQ -- requirements
Module: dec24_seq

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 10, meaning cycles per step in scan mode (legal 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the accepted-code counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 en  input  1  block enable; gates code acceptance and scan operation.
REQ-006 scan  input  1  scan-mode request; 1 = self-stepping one-hot sweep.
REQ-007 in_valid  input  1  A/B code valid.
REQ-008 in_ready  output  1  block can accept a code this cycle.
REQ-009 A  input  1  code MSB.
REQ-010 B  input  1  code LSB.
REQ-011 out_valid  output  1  a..d carry a valid one-hot word.
REQ-012 out_ready  input  1  consumer accepts the current word.
REQ-013 a, b, c, d  output  1 each  one-hot decode: a={A,B}=00, b=01, c=10, d=11.
REQ-014 count  output  CNT_W  number of codes accepted in direct mode, saturating.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE (out_valid=0), HOLD (direct-mode word pending, out_valid=1), SCAN (out_valid=1).
REQ-016 SHALL register a, b, c, d and out_valid; no combinational path from A/B to a..d.
REQ-017 SHALL drive a..d = 0000 whenever out_valid=0, and exactly one of a..d high whenever out_valid=1.
REQ-018 SHALL drive in_ready = en & ~scan & (state==IDLE | (state==HOLD & out_ready)); in_ready SHALL be 0 in SCAN.
REQ-019 SHALL accept a code on a cycle with in_valid & in_ready; its decoded word appears with out_valid=1 on the next cycle (latency 1).
REQ-020 IDLE: en & scan -> SCAN; else accept -> HOLD; else stay.
REQ-021 HOLD: SHALL hold a..d stable until out_ready=1; out_ready & accept -> HOLD with the new word (back-to-back, no bubble); out_ready & no accept -> IDLE.
REQ-022 HOLD with scan=1: SHALL refuse new codes; SHALL enter SCAN only after IDLE is reached via consumption of the pending word.
REQ-023 en=0 in HOLD: pending word SHALL be retained and remain consumable; no new acceptance.
REQ-024 SCAN entry: step counter SHALL load 0 (output a=1 on first SCAN cycle) and divider SHALL load 0.
REQ-025 SCAN: the step SHALL advance 0->1->2->3->0 when the divider reaches SCAN_DIV-1, i.e. each one-hot value is held exactly SCAN_DIV cycles; out_ready SHALL be ignored.
REQ-026 SCAN with scan=0 or en=0: SHALL go to IDLE next cycle (out_valid=0, a..d=0000).
REQ-027 count SHALL increment by 1 per accepted code and saturate at 2^CNT_W-1 (no wrap); scan steps SHALL NOT affect count.
REQ-028 Simultaneous out_ready and accept in HOLD SHALL count the new code and present it the next cycle.

Reset
REQ-029 On clk rising edge with rst_n=0: state=IDLE, out_valid=0, a..d=0000, count=0, step and divider=0, in_ready=0 during reset.
REQ-030 Reset asserted mid-HOLD or mid-SCAN SHALL discard the pending word/sweep; first cycle after release SHALL be IDLE.

Verification
REQ-031 en=1, scan=0, out_ready=1, stream codes 00,01,10,11 one per cycle -> a,b,c,d pulse one-hot in order one cycle later, no bubbles, count=4.
REQ-032 out_ready=0, send code 10 -> c=1, out_valid=1 held, in_ready=0; raise out_ready with in_valid=0 -> IDLE, a..d=0000 next cycle.
REQ-033 scan=1, en=1, SCAN_DIV=3 -> a for 3 cycles, b 3, c 3, d 3, then a again; in_ready=0; count unchanged.
REQ-034 scan=1 while a word is pending in HOLD with out_ready=0 -> word held, no SCAN; assert out_ready -> IDLE then SCAN with a=1.
REQ-035 CNT_W=2, accept 5 codes -> count 1,2,3,3,3.
REQ-036 rst_n=0 for one cycle during SCAN step 2 -> next cycle out_valid=0, a..d=0000, count=0.
